// File: rtl/core_rvfi_trace_pkg.sv
// ---------------------------------------------------------------------------
// core_rvfi_trace_pkg
// Shared types and constants for the RVFI retirement trace buffer.
//   XLEN        : data/address width of the traced core (fixed here so the
//                 record struct can be shared by every file of the block)
//   trace_rec_t : one captured retirement as presented on the trace stream
//   TRACE_REC_W : packed width of trace_rec_t (FIFO storage width)
//   DROP_CNT_W  : width of the saturating drop counter
// Build option: RVFI_TRACE_TSTAMP_EN adds a 64-bit push timestamp to the
// record.
// ---------------------------------------------------------------------------
package core_rvfi_trace_pkg;

  localparam int XLEN       = 64;
  localparam int ORDER_W    = 64;
  localparam int TSTAMP_W   = 64;
  localparam int DROP_CNT_W = 32;

  typedef struct packed {
`ifdef RVFI_TRACE_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
    logic [ORDER_W-1:0]  order;
    logic [31:0]         insn;
    logic [XLEN-1:0]     pc_rdata;
    logic [XLEN-1:0]     pc_wdata;
    logic [4:0]          rd_addr;
    logic [XLEN-1:0]     rd_wdata;
    logic                trap;
    logic                intr;
    logic                gap;   // first record after one or more drops
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/core_rvfi_trace_if.sv
// ---------------------------------------------------------------------------
// core_rvfi_trace_if
// Valid/ready trace stream carrying one retirement record per beat.
//   t_valid  : head record available        (master -> slave)
//   t_ready  : sink accepts the head record  (slave  -> master)
//   t_record : head record                   (master -> slave)
//   t_tstamp : push timestamp, only with RVFI_TRACE_TSTAMP_EN
// ---------------------------------------------------------------------------
interface core_rvfi_trace_if;
  import core_rvfi_trace_pkg::*;

  logic       t_valid;
  logic       t_ready;
  trace_rec_t t_record;
`ifdef RVFI_TRACE_TSTAMP_EN
  logic [TSTAMP_W-1:0] t_tstamp;
`endif

  modport master (
    output t_valid,
    output t_record,
`ifdef RVFI_TRACE_TSTAMP_EN
    output t_tstamp,
`endif
    input  t_ready
  );

  modport slave (
    input  t_valid,
    input  t_record,
`ifdef RVFI_TRACE_TSTAMP_EN
    input  t_tstamp,
`endif
    output t_ready
  );

endinterface

// File: rtl/core_rvfi_trace_fifo.sv
// ---------------------------------------------------------------------------
// core_rvfi_trace_fifo
// Generic synchronous FIFO, synchronous active-low reset.
//   g_clk, g_resetn : clock / reset
//   push_i, wdata_i : write strobe and data (ignored when full, unless a pop
//                     happens in the same cycle)
//   pop_i           : remove head entry (ignored when empty)
//   rdata_o         : head entry, read straight from storage registers
//   full_o, empty_o : occupancy flags decoded from the count register
// DEPTH must be a power of two >= 2 so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module core_rvfi_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO popped this cycle frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the count register alone decides what is valid.
  always_ff @(posedge g_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/core_rvfi_trace.sv
// ---------------------------------------------------------------------------
// core_rvfi_trace
// Retirement trace buffer behind the core's RVFI stage. Captures each valid
// retirement (while trace_en) into a FIFO and drains it over a valid/ready
// stream. Never stalls the core: retirements arriving at a full FIFO are
// dropped, counted, and the next stored record is flagged with gap=1.
// Also checks that rvfi_order is contiguous (sticky order_err).
//   g_clk, g_resetn : clock / synchronous active-low reset
//   trace_en        : capture enable (filtered retirements are not drops)
//   rvfi_*          : RVFI retirement inputs
//   clr             : clears drop_count and order_err, FIFO kept
//   drop_count      : saturating count of dropped retirements
//   order_err       : sticky non-contiguous rvfi_order flag
//   t_if            : trace stream (master side)
// Build option: RVFI_TRACE_TSTAMP_EN stores a free-running 64-bit cycle
// count in each record and drives t_if.t_tstamp.
// ---------------------------------------------------------------------------
module core_rvfi_trace
  import core_rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  trace_en,
  input  logic                  rvfi_valid,
  input  logic [ORDER_W-1:0]    rvfi_order,
  input  logic [31:0]           rvfi_insn,
  input  logic [XLEN-1:0]       rvfi_pc_rdata,
  input  logic [XLEN-1:0]       rvfi_pc_wdata,
  input  logic [4:0]            rvfi_rd_addr,
  input  logic [XLEN-1:0]       rvfi_rd_wdata,
  input  logic                  rvfi_trap,
  input  logic                  rvfi_intr,
  input  logic                  clr,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  order_err,
  core_rvfi_trace_if.master     t_if
);

  logic cap, pop, push, drop, full, empty, mismatch;

  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  logic                  order_err_q, order_err_d;
  logic                  gap_pend_q, gap_pend_d;
  logic                  first_seen_q, first_seen_d;
  logic [ORDER_W-1:0]    exp_order_q, exp_order_d;

  trace_rec_t             wr_rec, rd_rec;
  logic [TRACE_REC_W-1:0] wr_bits, rd_bits;

  assign cap  = rvfi_valid && trace_en;
  assign pop  = t_if.t_valid && t_if.t_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

`ifdef RVFI_TRACE_TSTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) tstamp_q <= '0;
    else           tstamp_q <= tstamp_q + 1'b1;
  end

  assign t_if.t_tstamp = rd_rec.tstamp;
`endif

  always_comb begin
    wr_rec          = '0;
    wr_rec.order    = rvfi_order;
    wr_rec.insn     = rvfi_insn;
    wr_rec.pc_rdata = rvfi_pc_rdata;
    wr_rec.pc_wdata = rvfi_pc_wdata;
    wr_rec.rd_addr  = rvfi_rd_addr;
    wr_rec.rd_wdata = rvfi_rd_wdata;
    wr_rec.trap     = rvfi_trap;
    wr_rec.intr     = rvfi_intr;
    wr_rec.gap      = gap_pend_q;
`ifdef RVFI_TRACE_TSTAMP_EN
    wr_rec.tstamp   = tstamp_q;
`endif
  end

  assign wr_bits = wr_rec;

  core_rvfi_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push_i   (push),
    .wdata_i  (wr_bits),
    .pop_i    (pop),
    .rdata_o  (rd_bits),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign rd_rec        = trace_rec_t'(rd_bits);
  assign t_if.t_record = rd_rec;
  assign t_if.t_valid  = !empty;

  // Order tracking sees every retirement, captured, dropped or filtered;
  // the very first one after reset only seeds the expectation.
  assign mismatch = rvfi_valid && first_seen_q && (rvfi_order != exp_order_q);

  always_comb begin
    drop_count_d = drop_count_q;
    if (clr)       drop_count_d = '0;   // clear beats a same-cycle drop
    else if (drop) drop_count_d = sat_inc(drop_count_q);

    // A same-cycle mismatch survives clr.
    order_err_d  = (order_err_q && !clr) || mismatch;

    gap_pend_d   = gap_pend_q;
    if (drop)      gap_pend_d = 1'b1;
    else if (push) gap_pend_d = 1'b0;

    first_seen_d = first_seen_q || rvfi_valid;
    exp_order_d  = rvfi_valid ? rvfi_order + 1'b1 : exp_order_q;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      drop_count_q <= '0;
      order_err_q  <= 1'b0;
      gap_pend_q   <= 1'b0;
      first_seen_q <= 1'b0;
      exp_order_q  <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      order_err_q  <= order_err_d;
      gap_pend_q   <= gap_pend_d;
      first_seen_q <= first_seen_d;
      exp_order_q  <= exp_order_d;
    end
  end

  assign drop_count = drop_count_q;
  assign order_err  = order_err_q;

endmodule

// File: tb/tb_core_rvfi_trace.sv
// ---------------------------------------------------------------------------
// tb_core_rvfi_trace
// Self-checking bench for core_rvfi_trace. Stimulus calls update a
// behavioural model (queue of expected records, occupancy, drop/gap/order
// state) and push expected records into a scoreboard; a monitor pops and
// compares whenever the DUT hands over a record. Directed scenarios are
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_core_rvfi_trace;
  import core_rvfi_trace_pkg::*;

  localparam int DEPTH = 8;

  logic                  g_clk = 1'b0;
  logic                  g_resetn = 1'b0;
  logic                  trace_en = 1'b0;
  logic                  rvfi_valid = 1'b0;
  logic [ORDER_W-1:0]    rvfi_order = '0;
  logic [31:0]           rvfi_insn = '0;
  logic [XLEN-1:0]       rvfi_pc_rdata = '0;
  logic [XLEN-1:0]       rvfi_pc_wdata = '0;
  logic [4:0]            rvfi_rd_addr = '0;
  logic [XLEN-1:0]       rvfi_rd_wdata = '0;
  logic                  rvfi_trap = 1'b0;
  logic                  rvfi_intr = 1'b0;
  logic                  clr = 1'b0;
  logic [DROP_CNT_W-1:0] drop_count;
  logic                  order_err;

  core_rvfi_trace_if t_if ();

  core_rvfi_trace #(.DEPTH(DEPTH)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .trace_en      (trace_en),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_trap     (rvfi_trap),
    .rvfi_intr     (rvfi_intr),
    .clr           (clr),
    .drop_count    (drop_count),
    .order_err     (order_err),
    .t_if          (t_if)
  );

  always #5 g_clk = ~g_clk;

  // Reference model state
  trace_rec_t   exp_q[$];
  int           m_cnt = 0;
  logic [31:0]  m_drop = '0;
  bit           m_gap = 1'b0;
  bit           m_err = 1'b0;
  bit           m_seen = 1'b0;
  logic [63:0]  m_next = '0;
  logic [63:0]  m_cyc = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat transfers at the next rising edge when valid && ready.
  initial begin
    trace_rec_t e;
    forever begin
      @(negedge g_clk);
      if (g_resetn && t_if.t_valid === 1'b1 && t_if.t_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_record: got order %0h, expected no record (t=%0t)",
                   t_if.t_record.order, $time);
        end else begin
          e = exp_q.pop_front();
          if (t_if.t_record !== e) begin
            n_bad++;
            $display("FAIL record: got %h expected %h (t=%0t)", t_if.t_record, e, $time);
          end
`ifdef RVFI_TRACE_TSTAMP_EN
          check("t_tstamp", t_if.t_tstamp, e.tstamp);
`endif
        end
      end
    end
  end

  // One clock of stimulus; the model applies the same cycle's effect.
  task automatic step(input bit v, input bit en, input logic [63:0] ord,
                      input bit rdy, input bit c);
    trace_rec_t rec;
    bit popm, capm;
    rvfi_valid    = v;
    trace_en      = en;
    rvfi_order    = ord;
    rvfi_insn     = $urandom;
    rvfi_pc_rdata = {$urandom, $urandom};
    rvfi_pc_wdata = {$urandom, $urandom};
    rvfi_rd_addr  = 5'($urandom);
    rvfi_rd_wdata = {$urandom, $urandom};
    rvfi_trap     = 1'($urandom);
    rvfi_intr     = 1'($urandom);
    t_if.t_ready  = rdy;
    clr           = c;

    popm = (m_cnt > 0) && rdy;
    capm = v && en;
    if (c) m_drop = '0;
    if (capm) begin
      if (m_cnt < DEPTH || popm) begin
        rec          = '0;
        rec.order    = ord;
        rec.insn     = rvfi_insn;
        rec.pc_rdata = rvfi_pc_rdata;
        rec.pc_wdata = rvfi_pc_wdata;
        rec.rd_addr  = rvfi_rd_addr;
        rec.rd_wdata = rvfi_rd_wdata;
        rec.trap     = rvfi_trap;
        rec.intr     = rvfi_intr;
        rec.gap      = m_gap;
`ifdef RVFI_TRACE_TSTAMP_EN
        rec.tstamp   = m_cyc;
`endif
        exp_q.push_back(rec);
        m_cnt++;
        m_gap = 1'b0;
      end else begin
        m_gap = 1'b1;
        if (!c && m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
    if (popm) m_cnt--;
    if (c) m_err = 1'b0;
    if (v) begin
      if (m_seen && ord != m_next) m_err = 1'b1;
      m_next = ord + 64'd1;
      m_seen = 1'b1;
    end

    @(posedge g_clk);
    #1;
    m_cyc++;
    check("t_valid", 64'(t_if.t_valid), 64'(m_cnt > 0));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    check("order_err", 64'(order_err), 64'(m_err));
  endtask

  task automatic do_reset();
    g_resetn     = 1'b0;
    rvfi_valid   = 1'b0;
    trace_en     = 1'b0;
    clr          = 1'b0;
    t_if.t_ready = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_drop = '0; m_gap = 1'b0; m_err = 1'b0; m_seen = 1'b0; m_next = '0;
    @(posedge g_clk);
    #1;
    check("rst_t_valid", 64'(t_if.t_valid), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_order_err", 64'(order_err), 64'd0);
    g_resetn = 1'b1;
    m_cyc    = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_cnt > 0; i++) step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    check("drain_t_valid", 64'(t_if.t_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] ord;
    t_if.t_ready = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    do_reset();

    // Basic ordering: record visible the cycle after capture.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 64'(i), 1'b1, 1'b0);
      if (i == 0) check("push_latency", 64'(t_if.t_valid), 64'd1);
    end
    drain();
    check("basic_order_err", 64'(order_err), 64'd0);

    // Overflow: 11 retirements into a stalled 8-deep FIFO.
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 1'b0);
    check("overflow_drop_count", 64'(drop_count), 64'd3);
    drain();
    step(1'b1, 1'b1, 64'd11, 1'b0, 1'b0);
    check("gap_marked", 64'(t_if.t_record.gap), 64'd1);
    check("gap_order", t_if.t_record.order, 64'd11);
    drain();

    // Full with simultaneous pop: push accepted, occupancy stays at DEPTH,
    // so the following stalled retirement is dropped.
    for (int i = 12; i < 20; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'd20, 1'b1, 1'b0);
    check("full_pop_no_drop", 64'(drop_count), 64'd3);
    step(1'b1, 1'b1, 64'd21, 1'b0, 1'b0);
    check("full_pop_still_full", 64'(drop_count), 64'd4);
    drain();

    // Order gap, then clr in the same cycle as a drop.
    do_reset();
    step(1'b1, 1'b1, 64'd5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'd6, 1'b1, 1'b0);
    check("no_err_contiguous", 64'(order_err), 64'd0);
    step(1'b1, 1'b1, 64'd8, 1'b1, 1'b0);
    check("order_err_after_gap", 64'(order_err), 64'd1);
    drain();
    for (int i = 9; i < 17; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'd17, 1'b0, 1'b0);
    check("drop_before_clr", 64'(drop_count), 64'd1);
    step(1'b1, 1'b1, 64'd18, 1'b0, 1'b1);
    check("clr_beats_drop", 64'(drop_count), 64'd0);
    check("clr_clears_err", 64'(order_err), 64'd0);
    drain();

    // Capture disabled: nothing stored or dropped, order still tracked.
    for (int i = 19; i < 22; i++) step(1'b1, 1'b0, 64'(i), 1'b1, 1'b0);
    check("disabled_no_record", 64'(t_if.t_valid), 64'd0);
    check("disabled_no_drop", 64'(drop_count), 64'd0);
    step(1'b1, 1'b1, 64'd22, 1'b1, 1'b0);
    check("disabled_order_tracked", 64'(order_err), 64'd0);
    drain();

    // Reset with four entries queued.
    for (int i = 23; i < 27; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 64'd100, 1'b0, 1'b0);
`ifdef RVFI_TRACE_TSTAMP_EN
    check("first_tstamp", t_if.t_tstamp, 64'd0);
`endif
    drain();

    // Randomized traffic.
    ord = 64'd101;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom_range(0, 9) < 7);
      if (v && $urandom_range(0, 19) == 0) ord = ord + 64'($urandom_range(2, 9));
      step(v, ($urandom_range(0, 6) != 0), ord, 1'($urandom), ($urandom_range(0, 29) == 0));
      if (v) ord = ord + 64'd1;
    end
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
